// File: rtl/tlul_pkg.sv
// TL-UL channel bundles shared by hosts and devices.
// Widths follow the common 32-bit TL-UL profile.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_AUW = 16;
  localparam int TL_DUW = 16;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_AUW-1:0] a_user;
    logic              d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tlul_d2h_t;

endpackage

// File: rtl/tlul_reg_host.sv
// Single-outstanding TL-UL host bridging a simple register request port.
// Times out stalled responses and drops late D beats while idle.
module tlul_reg_host
  import tlul_pkg::*;
#(
  parameter int          AW            = 32,
  parameter int          DW            = 32,
  parameter int unsigned SourceId      = 0,
  parameter int          TimeoutCycles = 1024,
  localparam int         DBW           = DW / 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req_i,
  input  logic           we_i,
  input  logic [AW-1:0]  addr_i,
  input  logic [DW-1:0]  wdata_i,
  input  logic [DBW-1:0] be_i,
  output logic           ready_o,
  output logic           rsp_valid_o,
  output logic [DW-1:0]  rdata_o,
  output logic           err_o,
  output tlul_h2d_t      tl_o,
  input  tlul_d2h_t      tl_i
);

  localparam int OffW = $clog2(DBW);
  localparam int CW   = $clog2(TimeoutCycles);
  localparam logic [CW-1:0] TMax = CW'(TimeoutCycles - 1);
  localparam logic [TL_AIW-1:0] SrcId = TL_AIW'(SourceId);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  state_e         state_q;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [DBW-1:0] be_q;
  logic [CW-1:0]  cnt_q;
  logic           rsp_valid_q;
  logic           err_q;
  logic [DW-1:0]  rdata_q;

  logic           rsp_err;
  logic [2:0]     a_op;
  logic [AW-1:0]  addr_al;

  assign rsp_err = tl_i.d_error | (tl_i.d_source != SrcId);
  assign addr_al = {addr_q[AW-1:OffW], {OffW{1'b0}}};

  always_comb begin
    a_op = Get;
    unique case (1'b1)
      !we_q:           a_op = Get;
      we_q && &be_q:   a_op = PutFullData;
      we_q && !(&be_q): a_op = PutPartialData;
      default:         a_op = Get;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (tl_i.a_ready) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // A response on the timeout cycle still counts as a response.
          if (tl_i.d_valid) begin
            rsp_valid_q <= 1'b1;
            err_q       <= rsp_err;
            if (!we_q && !rsp_err) begin
              rdata_q <= tl_i.d_data[DW-1:0];
            end
            state_q <= IDLE;
          end else if (cnt_q == TMax) begin
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == REQ);
    tl_o.a_opcode  = a_op;
    tl_o.a_size    = TL_SZW'(OffW);
    tl_o.a_source  = SrcId;
    tl_o.a_address = TL_AW'(addr_al);
    tl_o.a_mask    = we_q ? TL_DBW'(be_q) : '1;
    tl_o.a_data    = we_q ? TL_DW'(wdata_q) : '0;
    tl_o.d_ready   = (state_q != REQ);
  end

  logic unused_tl;
  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                       tl_i.d_sink, tl_i.d_user, addr_q[OffW-1:0]};

endmodule

// File: doc/tlul_reg_host.md
TLUL_REG_HOST -- requirements
Module: tlul_reg_host

Interface
REQ-001 Parameters SHALL be: AW, default 32, request address width; DW, default 32, data width; DBW, fixed DW/8, byte-enable width, not overridable; SourceId, default 0, a_source value; TimeoutCycles, default 1024, WAIT-state timeout in cycles, minimum 2.
REQ-002 clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 req_i  input  1  local request valid.
REQ-005 we_i  input  1  1 = write, 0 = read.
REQ-006 addr_i  input  AW  byte address.
REQ-007 wdata_i  input  DW  write data.
REQ-008 be_i  input  DBW  byte enables.
REQ-009 ready_o  output  1  host can accept a request.
REQ-010 rsp_valid_o  output  1  one-cycle response pulse.
REQ-011 rdata_o  output  DW  read data, held until the next response.
REQ-012 err_o  output  1  response error, qualified by rsp_valid_o.
REQ-013 tl_o  output  tlul_pkg::tlul_h2d_t  TL-UL host-to-device channel.
REQ-014 tl_i  input  tlul_pkg::tlul_d2h_t  TL-UL device-to-host channel.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ (A channel driven) and WAIT (awaiting D channel), with at most one transaction outstanding.
REQ-016 ready_o SHALL equal (state==IDLE); a request SHALL be accepted in any cycle with req_i & ready_o.
REQ-017 On acceptance, we_i, addr_i, wdata_i and be_i SHALL be latched, and the state SHALL move to REQ on the next edge; inputs SHALL be ignored outside acceptance cycles.
REQ-018 In REQ, a_valid SHALL be 1 with all A fields driven from registers; the state SHALL stay in REQ until a_ready=1, then move to WAIT on that edge.
REQ-019 A fields SHALL be: a_opcode Get(4) for reads, PutFullData(0) for writes with all-ones be, and PutPartialData(1) for writes with any other be.
REQ-020 Further A fields SHALL be: a_size=log2(DBW); a_source=SourceId; a_address=latched address with its low log2(DBW) bits forced to 0; a_mask=latched be for writes and all-ones for reads; a_data=latched wdata for writes and 0 for reads; a_param=0; a_user=0.
REQ-021 d_ready SHALL be 1 in IDLE and WAIT and 0 in REQ.
REQ-022 In WAIT, a d_valid=1 cycle SHALL complete the transaction: rsp_valid_o pulses high for exactly the next cycle; err_o=d_error | (d_source!=SourceId); rdata_o=d_data for a read with no error, otherwise rdata_o is unchanged; state returns to IDLE.
REQ-023 The minimum latency SHALL be: acceptance at cycle N, a_valid from N+1, rsp_valid_o at N+3 when a_ready=1 at N+1 and d_valid=1 at N+2.
REQ-024 A timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle without d_valid.
REQ-025 When the counter reaches TimeoutCycles-1 without d_valid, the transaction SHALL end: rsp_valid_o=1 with err_o=1, rdata_o unchanged, state to IDLE.
REQ-026 d_valid arriving in the same cycle the timeout is reached SHALL win: it is treated as a normal response.
REQ-027 d_valid seen in IDLE (e.g. late after a timeout) SHALL be consumed and discarded with no rsp_valid_o pulse.
REQ-028 ready_o SHALL be high again in the cycle rsp_valid_o is high, so back-to-back requests are accepted in that cycle.

Reset
REQ-029 Assertion of rst_ni low SHALL immediately force state=IDLE and clear the timeout counter, regardless of any transaction in flight.
REQ-030 Reset values SHALL be: ready_o=1 once out of reset, rsp_valid_o=0, rdata_o=0, err_o=0, a_valid=0, all latched fields=0.
REQ-031 A transaction in flight at reset SHALL be abandoned, and its response, if any, SHALL be discarded per REQ-027.

Verification
REQ-032 Read: req_i with we_i=0, addr_i=0x0000_0013, with the device giving a_ready on the first cycle and d_data=0xDEAD_BEEF -> a_opcode=4, a_address=0x10, a_mask=0xF; rsp_valid_o at N+3; rdata_o=0xDEAD_BEEF; err_o=0.
REQ-033 Partial write: we_i=1, be_i=0x3, wdata_i=0x1234_5678, a_ready held low for 3 cycles -> a_valid stable for 4 cycles, a_opcode=1, a_mask=0x3, then one rsp_valid_o; a full write with be_i=0xF -> a_opcode=0.
REQ-034 Error: d_error=1, or d_source=SourceId+1 -> rsp_valid_o=1, err_o=1, rdata_o keeps its previous value.
REQ-035 Timeout: TimeoutCycles=8 with no d_valid -> rsp_valid_o with err_o=1 exactly 8 cycles after WAIT entry; a later d_valid is discarded; d_valid arriving on the 8th cycle -> normal response.
REQ-036 Reset mid-WAIT: rst_ni pulsed low -> immediately state=IDLE, ready_o=1 after release, rsp_valid_o=0; a subsequent read completes normally.
